// File: rtl/registers_pkg.sv
// Shared constants and scoreboard next-state helper for the parametrised register file.
package registers_pkg;

    localparam int unsigned ZERO_IDX   = 0;
    localparam int unsigned MAX_DEPTH  = 256;
    localparam int unsigned MAX_ADDR_W = 8;

    typedef logic [MAX_DEPTH-1:0]  busy_vec_t;
    typedef logic [MAX_ADDR_W-1:0] idx_t;

    typedef struct packed {
        logic en;
        idx_t idx;
    } busy_op_t;

    // Clears are applied before the set so a same-cycle reservation (new producer) wins.
    function automatic busy_vec_t busy_next(input busy_vec_t cur,
                                            input busy_op_t  clr0,
                                            input busy_op_t  clr1,
                                            input busy_op_t  set,
                                            input logic      zero_reg);
        busy_vec_t nxt;
        nxt = cur;
        if (clr0.en) nxt[clr0.idx] = 1'b0;
        if (clr1.en) nxt[clr1.idx] = 1'b0;
        if (set.en)  nxt[set.idx]  = 1'b1;
        if (zero_reg) nxt[ZERO_IDX] = 1'b0;
        return nxt;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: writes retire a producer, reservations mark a new one.
module reg_scoreboard
    import registers_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr0_en,
    input  logic [ADDR_W-1:0] i_clr0_idx,
    input  logic              i_clr1_en,
    input  logic [ADDR_W-1:0] i_clr1_idx,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_idx,
    output logic [DEPTH-1:0]  o_busy
);

    logic [DEPTH-1:0] r_busy;
    busy_vec_t        w_next;

    // DEPTH must not exceed MAX_DEPTH; the helper works on the widest vector.
    always_comb begin
        w_next = busy_next(busy_vec_t'(r_busy),
                           '{en: i_clr0_en, idx: idx_t'(i_clr0_idx)},
                           '{en: i_clr1_en, idx: idx_t'(i_clr1_idx)},
                           '{en: i_set_en,  idx: idx_t'(i_set_idx)},
                           ZERO_REG != 0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_busy <= '0;
        else       r_busy <= w_next[DEPTH-1:0];
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/registers_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD read ports,
// optional write-to-read bypass, optional hardwired zero register and busy scoreboard.
module registers_mp
    import registers_pkg::*;
#(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned BYPASS   = 0,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk_w_i,
    input  logic                     res_w_i_h,
    input  logic [NUM_RD*ADDR_W-1:0] rd_reg_w_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_w_o,
    output logic [NUM_RD-1:0]        rd_busy_w_o,
    input  logic [ADDR_W-1:0]        wr_reg_0_w_i,
    input  logic [DATA_W-1:0]        wr_data_0_w_i,
    input  logic                     wr_flag_0_w_i,
    input  logic [ADDR_W-1:0]        wr_reg_1_w_i,
    input  logic [DATA_W-1:0]        wr_data_1_w_i,
    input  logic                     wr_flag_1_w_i,
    input  logic [ADDR_W-1:0]        rsv_reg_w_i,
    input  logic                     rsv_flag_w_i,
    output logic [DEPTH-1:0]         busy_vec_w_o
);

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic                     w_wr0_en;
    logic                     w_wr1_en;
    logic                     w_rsv_en;
    logic [DEPTH-1:0]         w_busy;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_busy;
    logic [ADDR_W-1:0]        w_idx;
    logic [DATA_W-1:0]        w_data;

    // Qualifying enables against the zero register keeps r_mem[0] at 0 and excludes it from bypass.
    assign w_wr0_en = wr_flag_0_w_i && !(ZERO_REG != 0 && wr_reg_0_w_i == ADDR_W'(ZERO_IDX));
    assign w_wr1_en = wr_flag_1_w_i && !(ZERO_REG != 0 && wr_reg_1_w_i == ADDR_W'(ZERO_IDX));
    assign w_rsv_en = rsv_flag_w_i  && !(ZERO_REG != 0 && rsv_reg_w_i  == ADDR_W'(ZERO_IDX));

    // Port 1 is assigned last so it wins a same-index collision.
    always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
        if (res_w_i_h) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr0_en) r_mem[wr_reg_0_w_i] <= wr_data_0_w_i;
            if (w_wr1_en) r_mem[wr_reg_1_w_i] <= wr_data_1_w_i;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        w_idx     = '0;
        w_data    = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            w_idx  = rd_reg_w_i[k*ADDR_W +: ADDR_W];
            w_data = r_mem[w_idx];
            if (BYPASS != 0) begin
                if (w_wr0_en && wr_reg_0_w_i == w_idx) w_data = wr_data_0_w_i;
                if (w_wr1_en && wr_reg_1_w_i == w_idx) w_data = wr_data_1_w_i;
            end
            w_rd_data[k*DATA_W +: DATA_W] = w_data;
            w_rd_busy[k]                  = w_busy[w_idx];
        end
    end

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clk      (clk_w_i),
        .i_rst      (res_w_i_h),
        .i_clr0_en  (w_wr0_en),
        .i_clr0_idx (wr_reg_0_w_i),
        .i_clr1_en  (w_wr1_en),
        .i_clr1_idx (wr_reg_1_w_i),
        .i_set_en   (w_rsv_en),
        .i_set_idx  (rsv_reg_w_i),
        .o_busy     (w_busy)
    );

    assign rd_data_w_o  = w_rd_data;
    assign rd_busy_w_o  = w_rd_busy;
    assign busy_vec_w_o = w_busy;

endmodule

// File: tb/tb_registers_mp.sv
// Scoreboard bench: six configurations (NUM_RD 1/2/4 x BYPASS 0/1) share one stimulus stream
// and are compared against an array-based reference model.
module tb_registers_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int MAXRD = 4;
    localparam int NCFG  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [MAXRD*AW-1:0] rd_reg;
    logic              wr0_en, wr1_en, rsv_en;
    logic [AW-1:0]     wr0_reg, wr1_reg, rsv_reg;
    logic [DW-1:0]     wr0_data, wr1_data;

    logic [MAXRD*DW-1:0] rd_data_all [NCFG];
    logic [MAXRD-1:0]    rd_busy_all [NCFG];
    logic [DEPTH-1:0]    bvec_all    [NCFG];

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int NR = (c % 3 == 0) ? 1 : ((c % 3 == 1) ? 2 : 4);
        localparam int BP = c / 3;
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    b;
        registers_mp #(
            .DATA_W   (DW),
            .DEPTH    (DEPTH),
            .NUM_RD   (NR),
            .BYPASS   (BP),
            .ZERO_REG (1)
        ) u_dut (
            .clk_w_i       (clk),
            .res_w_i_h     (rst),
            .rd_reg_w_i    (rd_reg[NR*AW-1:0]),
            .rd_data_w_o   (d),
            .rd_busy_w_o   (b),
            .wr_reg_0_w_i  (wr0_reg),
            .wr_data_0_w_i (wr0_data),
            .wr_flag_0_w_i (wr0_en),
            .wr_reg_1_w_i  (wr1_reg),
            .wr_data_1_w_i (wr1_data),
            .wr_flag_1_w_i (wr1_en),
            .rsv_reg_w_i   (rsv_reg),
            .rsv_flag_w_i  (rsv_en),
            .busy_vec_w_o  (bvec_all[c])
        );
        assign rd_data_all[c] = (MAXRD*DW)'(d);
        assign rd_busy_all[c] = MAXRD'(b);
    end

    typedef struct packed {
        logic [MAXRD-1:0][DW-1:0] nb;
        logic [MAXRD-1:0][DW-1:0] byp;
        logic [MAXRD-1:0]         brd;
        logic [DEPTH-1:0]         bvec;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0]    m_mem [DEPTH];
    logic [DEPTH-1:0] m_busy;

    function automatic int nr_of(input int c);
        case (c % 3)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [MAXRD*AW-1:0] rdv(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                                input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Expected combinational outputs for the current inputs and model state.
    function automatic exp_t calc_exp();
        exp_t          e;
        logic [AW-1:0] idx;
        e.bvec = m_busy;
        for (int k = 0; k < MAXRD; k++) begin
            idx      = rd_reg[k*AW +: AW];
            e.nb[k]  = (idx == 0) ? '0 : m_mem[idx];
            e.byp[k] = e.nb[k];
            if (idx != 0 && wr0_en && wr0_reg == idx) e.byp[k] = wr0_data;
            if (idx != 0 && wr1_en && wr1_reg == idx) e.byp[k] = wr1_data;
            e.brd[k] = m_busy[idx];
        end
        return e;
    endfunction

    task automatic model_edge();
        if (wr0_en && wr0_reg != 0) m_mem[wr0_reg] = wr0_data;
        if (wr1_en && wr1_reg != 0) m_mem[wr1_reg] = wr1_data;
        if (wr0_en) m_busy[wr0_reg] = 1'b0;
        if (wr1_en) m_busy[wr1_reg] = 1'b0;
        if (rsv_en && rsv_reg != 0) m_busy[rsv_reg] = 1'b1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_busy = '0;
    endtask

    task automatic cycle(input logic [MAXRD*AW-1:0] r,
                         input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic es, input logic [AW-1:0] as_idx);
        @(posedge clk);
        #1;
        rd_reg  = r;
        wr0_en  = e0; wr0_reg = a0; wr0_data = d0;
        wr1_en  = e1; wr1_reg = a1; wr1_data = d1;
        rsv_en  = es; rsv_reg = as_idx;
        exp_q.push_back(calc_exp());
        model_edge();
    endtask

    // Reset asserted between edges; outputs must clear before the next posedge.
    task automatic rst_cycle(input logic [MAXRD*AW-1:0] r);
        @(posedge clk);
        #1;
        rd_reg = r;
        wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
        #1;
        rst = 1'b1;
        model_clear();
        exp_q.push_back(calc_exp());
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int c = 0; c < NCFG; c++) begin
                    for (int k = 0; k < nr_of(c); k++) begin
                        check($sformatf("cfg%0d rd%0d data", c, k), rd_data_all[c][k*DW +: DW],
                              (c >= 3) ? e.byp[k] : e.nb[k]);
                        check($sformatf("cfg%0d rd%0d busy", c, k), DW'(rd_busy_all[c][k]), DW'(e.brd[k]));
                    end
                    check($sformatf("cfg%0d busy_vec", c), bvec_all[c], e.bvec);
                end
            end
        end
    end

    initial begin : stimulus
        logic [MAXRD*AW-1:0] r;
        logic [AW-1:0]       a0, a1, as_idx;
        bit                  narrow;
        rst = 1'b0;
        rd_reg = '0;
        wr0_en = 1'b0; wr0_reg = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_reg = '0; wr1_data = '0;
        rsv_en = 1'b0; rsv_reg = '0;
        model_clear();

        rst_cycle(rdv(0, 1, 5, 31));
        // write r5, read it back, then reset mid-cycle
        cycle(rdv(5, 5, 5, 5), 1, 5, 32'hDEADBEEF, 0, 0, '0, 1, 5);
        cycle(rdv(5, 5, 5, 5), 0, 0, '0, 0, 0, '0, 0, 0);
        rst_cycle(rdv(5, 5, 5, 5));
        // dual write collision
        cycle(rdv(7, 7, 7, 7), 1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0);
        cycle(rdv(7, 7, 7, 7), 0, 0, '0, 0, 0, '0, 0, 0);
        // zero register
        cycle(rdv(0, 0, 0, 0), 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0);
        cycle(rdv(0, 0, 0, 0), 0, 0, '0, 0, 0, '0, 0, 0);
        // bypass onto read port 1
        cycle(rdv(0, 3, 3, 0), 1, 3, 32'hCAFEF00D, 0, 0, '0, 0, 0);
        cycle(rdv(3, 3, 3, 3), 0, 0, '0, 0, 0, '0, 0, 0);
        // scoreboard on r9
        cycle(rdv(9, 9, 9, 9), 0, 0, '0, 0, 0, '0, 1, 9);
        cycle(rdv(9, 9, 9, 9), 1, 9, 32'h99, 0, 0, '0, 1, 9);
        cycle(rdv(9, 9, 9, 9), 0, 0, '0, 1, 9, 32'h9999, 0, 0);
        cycle(rdv(9, 9, 9, 9), 0, 0, '0, 0, 0, '0, 0, 0);

        for (int i = 0; i < 10000; i++) begin
            narrow = ((i / 1000) % 2) == 1;
            for (int k = 0; k < MAXRD; k++)
                r[k*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
            a0     = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
            a1     = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
            as_idx = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
            if (i % 2500 == 1234)
                rst_cycle(r);
            else
                cycle(r, 1'($urandom_range(0, 1)), a0, $urandom,
                         1'($urandom_range(0, 1)), a1, $urandom,
                         1'($urandom_range(0, 1)), as_idx);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/registers_mp.md
Name: registers_mp

Overview:
- Parametrised successor to the CPU register file.
- Configurable width, depth and read-port count, plus two write ports with defined priority.
- Optional same-cycle write-to-read bypass, optional hardwired-zero register 0, and a per-register busy scoreboard for the pipelined core.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, >=2)
- ADDR_W, $clog2(DEPTH), register index width (derived, not overridden)
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 0, 1 = a write in the current cycle is visible on matching read ports combinationally
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
- clk_w_i  in  1  clock, rising edge
- res_w_i_h  in  1  reset, asynchronous, active-high
- rd_reg_w_i  in  NUM_RD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
- rd_data_w_o  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy_w_o  out  NUM_RD  scoreboard busy bit of each read-port register
- wr_reg_0_w_i  in  ADDR_W  write port 0 index
- wr_data_0_w_i  in  DATA_W  write port 0 data
- wr_flag_0_w_i  in  1  write port 0 enable
- wr_reg_1_w_i  in  ADDR_W  write port 1 index
- wr_data_1_w_i  in  DATA_W  write port 1 data
- wr_flag_1_w_i  in  1  write port 1 enable
- rsv_reg_w_i  in  ADDR_W  register to mark busy
- rsv_flag_w_i  in  1  reservation enable
- busy_vec_w_o  out  DEPTH  full scoreboard, bit i = register i busy

Behaviour:
- Reset: asynchronous. While res_w_i_h=1, all registers are 0 and all busy bits are 0. Hence rd_data_w_o=0, rd_busy_w_o=0 and busy_vec_w_o=0 during reset and immediately after it. Writes and reservations are ignored while reset is asserted.
- Reads are combinational from array state. With BYPASS=0, a register written at a posedge is readable after that edge (zero-cycle read latency, one-cycle write latency).
- BYPASS=1: if an enabled write index equals a read index this cycle, the read returns that write's data before the edge. If both write ports match, port 1 data is returned. Bypass never applies to register 0 when ZERO_REG=1.
- Writes happen on posedge when wr_flag_n=1.
- Both ports writing the same index in the same cycle: port 1 wins and port 0's data is dropped.
- ZERO_REG=1: writes to index 0 are discarded; reads of index 0 return 0; busy_vec_w_o[0] is held at 0.
- Scoreboard, at each posedge:
  - An enabled write to register i clears busy[i].
  - rsv_flag_w_i=1 sets busy[rsv_reg_w_i].
  - Same register cleared and reserved in the same cycle: the set wins (new producer), so busy stays 1.
  - Reserving an already-busy register leaves it at 1.
- rd_busy_w_o[k] = busy[rd_reg k], combinational from current state. Bypass does not affect busy.
- Index wrap: indices are exactly ADDR_W bits, so every index is in range; no out-of-range handling is needed.
- No handshake: every enabled operation is accepted every cycle.

Decomposition:
- Package registers_pkg holds the ZERO_IDX constant and the function computing the merged next-state busy vector.
- One sub-module, reg_scoreboard: busy vector plus set/clear logic. The data array, write priority and bypass muxing stay in registers_mp.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse res_w_i_h mid-cycle (not on an edge) -> rd_data for r5 is 0 before the next posedge; busy_vec=0.
- Dual write collision: port 0 writes r7=0x11111111 and port 1 writes r7=0x22222222 in the same cycle -> next cycle r7 reads 0x22222222.
- Zero register: write r0=0xFFFFFFFF on both ports and reserve r0 -> r0 reads 0; busy_vec[0]=0.
- Bypass (BYPASS=1): port 0 writes r3=0xCAFEF00D, read port 1 addresses r3 in the same cycle -> 0xCAFEF00D before the edge. With BYPASS=0 the same stimulus returns the old value 0x00000000.
- Scoreboard: reserve r9 -> busy[9]=1 next cycle. Write r9 and reserve r9 in the same cycle -> busy[9] stays 1. Write r9 only -> busy[9]=0.
- Random regression: 10,000 cycles per configuration (NUM_RD=1,2,4; BYPASS=0,1) with random indices, flags and data checked against a reference model on every posedge -> 0 errors.
